cell_truth_table_checker: RTL and testbench
===========================================

// Module: cell_truth_table_checker
// PURPOSE
//   Parametrised self-checking exhaustive-vector sequencer for combinational library cells
//   (OAI/AOI/NAND families, N inputs, M outputs).
//   Drives every input combination onto the DUT and waits a programmable settle time.
//   Samples the DUT outputs and compares them against an expected truth table.
//   Reports mismatch count, first failing vector and overall pass/fail.
//   Sits between the top-level bench and the cell under test, replacing hand-written
//   per-vector stimulus.
// PARAMETERS
//   N_IN          4         number of cell inputs; vector index = {in[N_IN-1]..in[0]}, MSB first
//   N_OUT         1         number of cell outputs
//   SETTLE        2         cycles each vector is held before sampling (>=1)
//   EXP_TABLE     16'h1FFF  expected outputs, 2**N_IN*N_OUT bits; entry i at [i*N_OUT +: N_OUT]
//                           (default = OAI211 with in order {A,B,C1,C2}: ZN=0 only at 13,14,15)
//   STOP_ON_FAIL  0         1: end run at first mismatch
// PORTS
//   clk             in   1        sole clock, rising edge
//   rst             in   1        synchronous, active-high reset
//   start           in   1        pulse; begins a run when idle
//   stim            out  N_IN     vector driven to DUT inputs
//   resp            in   N_OUT    DUT outputs
//   busy            out  1        high while a run is in progress
//   done            out  1        one-cycle pulse at end of run
//   pass            out  1        1 = last run had zero mismatches; held until next start
//   err_count       out  N_IN+1   mismatches in current/last run (saturates not needed: max 2**N_IN)
//   first_fail_vec  out  N_IN     index of first mismatching vector
//   first_fail_vld  out  1        first_fail_vec is valid
// BEHAVIOUR
//   - Reset: stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_vld=0,
//     state IDLE. Reset mid-run aborts immediately; no done pulse is issued.
//   - FSM IDLE -> APPLY -> CHECK -> (APPLY | FINISH) -> IDLE.
//   - IDLE: start=1 -> stim=0, busy=1, err_count=0, first_fail_vld=0, pass=0, settle cnt=SETTLE-1.
//   - APPLY: stim held; counts down; at count 0 go to CHECK next edge.
//     So resp is sampled SETTLE cycles after stim changes.
//   - CHECK, one cycle:
//     - compare resp vs EXP_TABLE[stim*N_OUT +: N_OUT]; X/Z on resp counts as mismatch
//       (case inequality in simulation).
//     - On mismatch: err_count++.
//     - On mismatch with first_fail_vld=0: first_fail_vec=stim, first_fail_vld=1.
//     - If stim==all-ones, or (STOP_ON_FAIL and mismatch) -> FINISH.
//     - Else stim++ and reload settle cnt -> APPLY.
//   - Vector counter is N_IN+1 bits internally; no wrap to 0 before the last vector is checked.
//   - FINISH: done=1 for one cycle, pass=(err_count_next==0), busy=0, stim returns to 0.
//     err_count and first_fail_* are held.
//   - Latency: full run = 1 + 2**N_IN*(SETTLE+1) + 1 cycles from start to done.
//   - start while busy (or in the done cycle) is ignored.
//   - start and rst together: rst wins.
// STRUCTURE
//   - Package cell_chk_pkg: state enum (IDLE, APPLY, CHECK, FINISH); function exp_bits(table,idx).
//   - Sub-module settle_timer: loadable down-counter with zero flag, width $clog2(SETTLE+1).
//   - Remainder (FSM, vector counter, comparator, error capture) is in this module.
// TESTING
//   1. Defaults, behavioural OAI211 DUT, start pulse:
//      done at cycle 50, pass=1, err_count=0, first_fail_vld=0.
//   2. DUT ZN stuck-at-1:
//      err_count=3, first_fail_vec=4'b1101, pass=0.
//   3. STOP_ON_FAIL=1, DUT ZN stuck-at-1:
//      done after vector 13 is checked, err_count=1, stim=0 after done.
//   4. rst asserted while stim=5:
//      all outputs 0 next cycle, no done pulse; new start runs cleanly to pass=1.
//   5. start re-pulsed at stim=3:
//      ignored, run completes unchanged; resp forced X on vector 7 -> err_count=1, first_fail_vec=7.
//   6. N_IN=2, SETTLE=1, EXP_TABLE=4'b0111, NAND2 DUT:
//      pass=1, done at cycle 10.

Source files
------------

// File: rtl/cell_chk_pkg.sv
// Shared types and truth-table helper for the cell truth-table checker.
// No logic of its own; table width is capped at MAX_TBL_W bits and outputs at MAX_OUT_W.
package cell_chk_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, FINISH} state_t;

  localparam int unsigned MAX_TBL_W = 1024;
  localparam int unsigned MAX_OUT_W = 16;

  // Expected output word for vector idx; bits at and above n_out are forced to zero.
  function automatic logic [MAX_OUT_W-1:0] exp_bits(input logic [MAX_TBL_W-1:0] tbl,
                                                    input int unsigned          idx,
                                                    input int unsigned          n_out);
    logic [MAX_TBL_W-1:0] sh;
    logic [MAX_OUT_W-1:0] mask;
    sh   = tbl >> (idx * n_out);
    mask = ~({MAX_OUT_W{1'b1}} << n_out);
    return sh[MAX_OUT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with zero flag, used to hold each vector before sampling.
// Latency: zero asserts load_val enabled cycles after load; no backpressure, holds at zero.
// Load has priority over counting.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cell_truth_table_checker.sv
// Exhaustive-vector sequencer: drives every input code to a cell and checks it against a table.
// Latency: start to done = 1 + 2**N_IN*(SETTLE+1) + 1 cycles (less when stopping at first fail).
// Backpressure: none; start is only accepted in IDLE, ignored while busy or during done.
module cell_truth_table_checker
  import cell_chk_pkg::*;
#(
  parameter int                          N_IN         = 4,
  parameter int                          N_OUT        = 1,
  parameter int                          SETTLE       = 2,
  parameter logic [(2**N_IN)*N_OUT-1:0]  EXP_TABLE    = 16'h1FFF,
  parameter bit                          STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_vld
);

  localparam int            TW       = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [N_IN:0] LAST_VEC = (N_IN + 1)'((2 ** N_IN) - 1);

  state_t                 state, state_nxt;
  logic [N_IN:0]          vec;
  logic [N_IN:0]          err_q, err_nxt;
  logic [N_IN-1:0]        ff_q;
  logic                   ff_vld_q, pass_q;

  logic                   tmr_load, tmr_en, tmr_zero;
  logic                   run_start, do_check, mismatch;
  logic [MAX_TBL_W-1:0]   tbl_ext;
  logic [MAX_OUT_W-1:0]   exp_word, resp_ext;

  assign tbl_ext = MAX_TBL_W'(EXP_TABLE);

  settle_timer #(.W(TW)) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (TW'(SETTLE - 1)),
    .zero     (tmr_zero)
  );

  // Case inequality so an X/Z response is treated as a failing vector in simulation.
  always_comb begin
    exp_word = exp_bits(tbl_ext, 32'(vec), N_OUT);
    resp_ext = MAX_OUT_W'(resp);
    mismatch = (resp_ext !== exp_word);
    err_nxt  = err_q + (N_IN + 1)'(mismatch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    run_start = 1'b0;
    do_check  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = APPLY;
          tmr_load  = 1'b1;
          run_start = 1'b1;
        end
      end
      APPLY: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_nxt = CHECK;
      end
      CHECK: begin
        do_check = 1'b1;
        if (vec == LAST_VEC || (STOP_ON_FAIL && mismatch)) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = APPLY;
          tmr_load  = 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector counter is one bit wider than stim so the last code never aliases to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec      <= '0;
      err_q    <= '0;
      ff_q     <= '0;
      ff_vld_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      if (run_start) begin
        vec      <= '0;
        err_q    <= '0;
        ff_vld_q <= 1'b0;
        pass_q   <= 1'b0;
      end
      if (do_check) begin
        if (mismatch) begin
          err_q <= err_nxt;
          if (!ff_vld_q) begin
            ff_q     <= vec[N_IN-1:0];
            ff_vld_q <= 1'b1;
          end
        end
        if (state_nxt == FINISH) begin
          pass_q <= (err_nxt == '0);
          vec    <= '0;
        end else begin
          vec <= vec + (N_IN + 1)'(1);
        end
      end
    end
  end

  assign stim           = vec[N_IN-1:0];
  assign busy           = (state == APPLY) || (state == CHECK);
  assign done           = (state == FINISH);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ff_q;
  assign first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_cell_truth_table_checker.sv
// Bench for cell_truth_table_checker: three instances (default OAI211, stop-on-fail, NAND2)
// driven from a run table plus hand sequences; done pulses are scored against a queue.
module tb_cell_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_s, start_n;
  logic [3:0] stim_a, stim_s, ff_a, ff_s;
  logic [1:0] stim_n, ff_n;
  logic       resp_a, resp_s, resp_n;
  logic       g_a, g_s, g_n;
  logic       busy_a, busy_s, busy_n, done_a, done_s, done_n;
  logic       pass_a, pass_s, pass_n, ffv_a, ffv_s, ffv_n;
  logic [4:0] err_a, err_s;
  logic [2:0] err_n;

  int   fault = 0;
  int   xvec  = -1;
  logic xlit;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  typedef struct {
    int unit; int exp_err; int exp_ff; bit exp_ffv; bit exp_pass; int exp_cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int unit; int fault; int err; int ff; bit ffv; bit pass; int lat;
  } vec_t;

  // Fault modes: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 inverted, 4 inverted on one vector.
  function automatic logic corrupt(input logic g, input int f, input bit hit);
    case (f)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return ~g;
      4:       return hit ? ~g : g;
      default: return g;
    endcase
  endfunction

  assign g_a    = ~(stim_a[3] & stim_a[2] & (stim_a[1] | stim_a[0]));
  assign g_s    = ~(stim_s[3] & stim_s[2] & (stim_s[1] | stim_s[0]));
  assign g_n    = ~(stim_n[1] & stim_n[0]);
  assign resp_a = (xvec >= 0 && int'(stim_a) == xvec) ? xlit : corrupt(g_a, fault, stim_a == 4'd9);
  assign resp_s = corrupt(g_s, fault, stim_s == 4'd9);
  assign resp_n = corrupt(g_n, fault, 1'b0);

  cell_truth_table_checker u_dut (
    .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .resp(resp_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail_vec(ff_a),
    .first_fail_vld(ffv_a));

  cell_truth_table_checker #(.STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst(rst), .start(start_s), .stim(stim_s), .resp(resp_s), .busy(busy_s),
    .done(done_s), .pass(pass_s), .err_count(err_s), .first_fail_vec(ff_s),
    .first_fail_vld(ffv_s));

  cell_truth_table_checker #(.N_IN(2), .SETTLE(1), .EXP_TABLE(4'b0111)) u_n2 (
    .clk(clk), .rst(rst), .start(start_n), .stim(stim_n), .resp(resp_n), .busy(busy_n),
    .done(done_n), .pass(pass_n), .err_count(err_n), .first_fail_vec(ff_n),
    .first_fail_vld(ffv_n));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    sb_t r;
    logic d, fv, p, b;
    int   e, f, s;
    for (int u = 0; u < 3; u++) begin
      case (u)
        0:       begin d = done_a; e = int'(err_a); f = int'(ff_a); fv = ffv_a; p = pass_a; b = busy_a; s = int'(stim_a); end
        1:       begin d = done_s; e = int'(err_s); f = int'(ff_s); fv = ffv_s; p = pass_s; b = busy_s; s = int'(stim_s); end
        default: begin d = done_n; e = int'(err_n); f = int'(ff_n); fv = ffv_n; p = pass_n; b = busy_n; s = int'(stim_n); end
      endcase
      if (d === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done_unit", u, -1);
        end else begin
          r = sb.pop_front();
          chk("done_unit", u, r.unit);
          chk("done_cycle", cyc, r.exp_cyc);
          chk("err_count", e, r.exp_err);
          chk("first_fail_vld", fv, r.exp_ffv);
          if (r.exp_ffv) chk("first_fail_vec", f, r.exp_ff);
          chk("pass", p, r.exp_pass);
          chk("busy_in_done", b, 0);
          chk("stim_in_done", s, 0);
        end
      end
    end
  end

  // Called on a negedge; start is sampled at the next posedge, done_cycle = cyc + lat.
  task automatic start_run(input int u, input int err, input int ff, input bit ffv,
                           input bit pass, input int lat);
    sb_t r;
    r = '{u, err, ff, ffv, pass, cyc + lat};
    sb.push_back(r);
    case (u)
      0:       start_a = 1'b1;
      1:       start_s = 1'b1;
      default: start_n = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0; start_s = 1'b0; start_n = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    bit seen;
    c0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (done_cnt != c0) seen = 1'b1;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_stim_a(input int val, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (int'(stim_a) == val) seen = 1'b1;
    end
    if (!seen) chk("stim_wait_timeout", 0, 1);
  endtask

  initial begin
    vec_t rows[12];
    int   c0;
    bit   m;
    bit   seen;

    // Latency 49 here is "done in cycle 50" when the start cycle is counted as cycle 1.
    rows[0]  = '{0, 0, 0,  0, 0, 1, 49};
    rows[1]  = '{0, 1, 3,  13, 1, 0, 49};
    rows[2]  = '{0, 2, 13, 0,  1, 0, 49};
    rows[3]  = '{0, 3, 16, 0,  1, 0, 49};
    rows[4]  = '{0, 4, 1,  9,  1, 0, 49};
    rows[5]  = '{1, 0, 0,  0,  0, 1, 49};
    rows[6]  = '{1, 1, 1,  13, 1, 0, 43};
    rows[7]  = '{1, 2, 1,  0,  1, 0, 4};
    rows[8]  = '{1, 4, 1,  9,  1, 0, 31};
    rows[9]  = '{2, 0, 0,  0,  0, 1, 9};
    rows[10] = '{2, 1, 1,  3,  1, 0, 9};
    rows[11] = '{2, 3, 4,  0,  1, 0, 9};

    xlit = 1'bx;
    rst = 1'b1; start_a = 1'b0; start_s = 1'b0; start_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stim", stim_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ffv", ffv_a, 0);
    chk("rst_ff", ff_a, 0);
    chk("rst_busy_n2", busy_n, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      fault = rows[i].fault;
      start_run(rows[i].unit, rows[i].err, rows[i].ff, rows[i].ffv, rows[i].pass, rows[i].lat);
      chk("busy_after_start", (rows[i].unit == 0) ? busy_a : (rows[i].unit == 1) ? busy_s : busy_n, 1);
      wait_done(200);
      repeat (2) @(negedge clk);
    end
    chk("stop_stim_idle", stim_s, 0);

    // Mid-run reset with start held: abort with no done, everything cleared.
    fault = 2;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_stim_a(5, 100);
    chk("abort_err_before", err_a, 5);
    chk("abort_ffv_before", ffv_a, 1);
    rst = 1'b1; start_a = 1'b1;
    c0 = done_cnt;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    chk("abort_stim", stim_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_err", err_a, 0);
    chk("abort_ffv", ffv_a, 0);
    chk("abort_ff", ff_a, 0);
    chk("abort_pass", pass_a, 0);
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_cnt, c0);
    fault = 0;
    start_run(0, 0, 0, 0, 1, 49);
    wait_done(200);

    // Re-pulsed start mid-run is ignored; X response on vector 7.
    xvec = 7;
    m = (xlit !== 1'b1);
    start_run(0, m ? 1 : 0, 7, m, !m, 49);
    wait_stim_a(3, 100);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done_a === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("done_wait_timeout", 0, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("start_in_done_busy", busy_a, 0);
    chk("start_in_done_stim", stim_a, 0);
    @(negedge clk);
    chk("start_in_done_idle", busy_a, 0);
    xvec = -1;

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
